// File: rtl/seq_signed_divider.sv
// ---------------------------------------------------------------------------
// seq_signed_divider
//
// Multi-cycle restoring divider. One division takes WIDTH+2 cycles from the
// accepting edge to the end of the done pulse, whatever the operand values:
//   IDLE -> RUN (WIDTH iterations) -> FIX (sign fix-up / result register)
//        -> DONE (one-cycle done pulse) -> IDLE
//
// Optional feature:
//   SEQ_SIGNED_DIVIDER_SIGNED_EN  defined   : two's complement operands/results
//                                 undefined : unsigned operands/results
//
// Ports:
//   clk_in          single clock, rising edge
//   rst_in          asynchronous active-high reset
//   start_in        begin a division (sampled only in IDLE)
//   dividend_in     dividend, captured on the accepting edge
//   divisor_in      divisor, captured on the accepting edge
//   busy_out        high while iterating (RUN) and fixing up (FIX)
//   done_out        one-cycle pulse in DONE
//   quotient_out    registered quotient (all ones on divide by zero)
//   remainder_out   registered remainder (dividend on divide by zero)
//   div_by_zero_out registered flag, divisor was zero
// ---------------------------------------------------------------------------
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               dbz_q, dbz_d;
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
`endif
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_out_q, dbz_out_d;

  logic [WIDTH+1:0]   trial;
  logic               fits;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    dbz_d       = dbz_q;
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_out_d   = dbz_out_q;

    // Shift the next dividend bit (held in the top of quo_q) into the
    // partial remainder; the extra top bit keeps the compare unsigned-safe.
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = (trial >= {2'b00, dsr_q});

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          dbz_d   = (divisor_in == '0);
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
          // Iterate on magnitudes; the most negative value maps to
          // 2**(WIDTH-1), which is still representable as unsigned.
          quo_d     = dividend_in[WIDTH-1] ? -dividend_in : dividend_in;
          dsr_d     = divisor_in[WIDTH-1] ? -divisor_in : divisor_in;
          neg_quo_d = dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
          neg_rem_d = dividend_in[WIDTH-1];
`else
          quo_d = dividend_in;
          dsr_d = divisor_in;
`endif
        end
      end

      RUN: begin
        // Restoring step: keep the difference only when the divisor fits.
        rem_d = fits ? (WIDTH+1)'(trial - {2'b00, dsr_q}) : trial[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d   = DONE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
        // A zero divisor yields an all-ones magnitude quotient; force all
        // ones so the sign fix-up cannot turn it into +1. The remainder
        // magnitude equals |dividend|, so re-signing restores the dividend.
        if (dbz_q) begin
          quotient_d = '1;
        end else begin
          quotient_d = neg_quo_q ? -quo_q : quo_q;
        end
        remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`else
        quotient_d  = quo_q;
        remainder_d = rem_q[WIDTH-1:0];
`endif
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      dbz_q       <= dbz_d;
`ifdef SEQ_SIGNED_DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_out_q   <= dbz_out_d;
    end
  end

  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign quotient_out    = quotient_q;
  assign remainder_out   = remainder_q;
  assign div_by_zero_out = dbz_out_q;

endmodule
